// File: rtl/scan_mux_if.sv
// scan_mux_if: request/result bundle for the scan_mux channel selector.
//
// Signals
//   d         packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel       channel index used in manual mode
//   in_valid  manual-mode request strobe
//   in_ready  request accepted this cycle when high
//   scan_en   level request for automatic scan mode
//   y         selected channel data
//   y_ch      index of the channel presented on y
//   out_valid y / y_ch hold a valid result
//   out_ready consumer accepts the result when high with out_valid
//
// Modports
//   master  the requester / consumer side (drives requests, takes results)
//   slave   the scan_mux side
interface scan_mux_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 64,
    parameter int SELW  = 6
);
    logic [NCH*WIDTH-1:0] d;
    logic [SELW-1:0]      sel;
    logic                 in_valid;
    logic                 in_ready;
    logic                 scan_en;
    logic [WIDTH-1:0]     y;
    logic [SELW-1:0]      y_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output d, sel, in_valid, scan_en, out_ready,
        input  in_ready, y, y_ch, out_valid
    );

    modport slave (
        input  d, sel, in_valid, scan_en, out_ready,
        output in_ready, y, y_ch, out_valid
    );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: two-stage pipelined NCH-to-1 channel selector with an optional
// automatic scan mode that walks every channel index in turn.
//
// Ports
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; clears the pipeline and the mode state
//   bus    scan_mux_if.slave (d, sel, in_valid, in_ready, scan_en,
//          y, y_ch, out_valid, out_ready)
//
// Configuration
//   SCAN_MUX_SCAN_EN  when defined, the MANUAL/SCAN mode FSM and scan counter
//                     are built; when undefined scan_en is ignored and the
//                     block always issues sel/in_valid.
//
// Stage 1 captures the candidate from the lower half and from the upper half
// of the index space (split on the index MSB) together with index and valid;
// stage 2 picks between them with the captured MSB. Indices >= NCH match no
// channel and so produce zero data.
module scan_mux #(
    parameter int WIDTH = 4,
    parameter int NCH   = 64,
    parameter int SELW  = 6
) (
    input logic      clk,
    input logic      reset,
    scan_mux_if.slave bus
);

    localparam logic [SELW-1:0] MSB_MASK = SELW'(1) << (SELW - 1);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);

    logic            en;
    logic [SELW-1:0] issue_idx;
    logic            issue_vld;

    logic [SELW-1:0]  lo_idx;
    logic [SELW-1:0]  hi_idx;
    logic [WIDTH-1:0] lo_pick;
    logic [WIDTH-1:0] hi_pick;

    logic [WIDTH-1:0] s1_lo_q,  s1_lo_d;
    logic [WIDTH-1:0] s1_hi_q,  s1_hi_d;
    logic [SELW-1:0]  s1_idx_q, s1_idx_d;
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] y_q,      y_d;
    logic [SELW-1:0]  y_ch_q,   y_ch_d;
    logic             out_valid_q, out_valid_d;

    // The whole pipeline advances together whenever the output slot is free
    // or being consumed.
    assign en           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = en;

`ifdef SCAN_MUX_SCAN_EN
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_t;

    mode_t           state_q, state_d;
    logic [SELW-1:0] cnt_q,   cnt_d;

    // In SCAN the counter supplies an always-valid request.
    always_comb begin
        issue_idx = bus.sel;
        issue_vld = bus.in_valid;
        if (state_q == SCAN) begin
            issue_idx = cnt_q;
            issue_vld = 1'b1;
        end
    end

    // The counter only moves when its request is actually accepted, so no
    // index is skipped while the output is stalled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == SCAN && en) begin
            cnt_d = (cnt_q == LAST_CH) ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            MANUAL: begin
                if (bus.scan_en) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (!bus.scan_en) begin
                    state_d = MANUAL;
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_scan_en;

    assign unused_scan_en = bus.scan_en;
    assign issue_idx      = bus.sel;
    assign issue_vld      = bus.in_valid;
`endif

    // Candidate channel in each half; an index with no matching channel
    // leaves the pick at zero, which is how out-of-range requests read 0.
    always_comb begin
        lo_idx  = issue_idx & ~MSB_MASK;
        hi_idx  = issue_idx | MSB_MASK;
        lo_pick = '0;
        hi_pick = '0;
        for (int k = 0; k < NCH; k++) begin
            if (lo_idx == SELW'(k)) begin
                lo_pick = bus.d[k*WIDTH +: WIDTH];
            end
            if (hi_idx == SELW'(k)) begin
                hi_pick = bus.d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        s1_lo_d     = s1_lo_q;
        s1_hi_d     = s1_hi_q;
        s1_idx_d    = s1_idx_q;
        s1_vld_d    = s1_vld_q;
        y_d         = y_q;
        y_ch_d      = y_ch_q;
        out_valid_d = out_valid_q;
        if (en) begin
            s1_lo_d     = lo_pick;
            s1_hi_d     = hi_pick;
            s1_idx_d    = issue_idx;
            s1_vld_d    = issue_vld;
            y_d         = s1_idx_q[SELW-1] ? s1_hi_q : s1_lo_q;
            y_ch_d      = s1_idx_q;
            out_valid_d = s1_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_lo_q     <= '0;
            s1_hi_q     <= '0;
            s1_idx_q    <= '0;
            s1_vld_q    <= 1'b0;
            y_q         <= '0;
            y_ch_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_lo_q     <= s1_lo_d;
            s1_hi_q     <= s1_hi_d;
            s1_idx_q    <= s1_idx_d;
            s1_vld_q    <= s1_vld_d;
            y_q         <= y_d;
            y_ch_q      <= y_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.y_ch      = y_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: scoreboard bench for scan_mux.
//
// Two instances run in lockstep from the same stimulus: one with the default
// 64 channels and one with 40 channels, so that indices 40..63 exercise the
// out-of-range path. Expected results are pushed when a request is accepted
// and popped by a monitor whenever a result transfers.
module tb_scan_mux;

    localparam int WIDTH = 4;
    localparam int NCH   = 64;
    localparam int SELW  = 6;
    localparam int NCH_S = 40;

`ifdef SCAN_MUX_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    typedef struct {
        logic [SELW-1:0]  ch;
        logic [WIDTH-1:0] y;
        int               acc;
        bit               strict;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    exp_t q64[$];
    exp_t q40[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    // Reference model state: operating mode and one scan counter per instance.
    bit scan_mode = 1'b0;
    int cnt64     = 0;
    int cnt40     = 0;

    // Output-hold tracking for the stall checks, one slot per instance.
    bit               prev_stall [2];
    logic [WIDTH-1:0] prev_y     [2];
    logic [SELW-1:0]  prev_ch    [2];

    scan_mux_if #(.WIDTH(WIDTH), .NCH(NCH),   .SELW(SELW)) bus64 ();
    scan_mux_if #(.WIDTH(WIDTH), .NCH(NCH_S), .SELW(SELW)) bus40 ();

    scan_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    scan_mux #(.WIDTH(WIDTH), .NCH(NCH_S), .SELW(SELW)) u_dut40 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus40)
    );

    // The small instance sees exactly the same requests; its d is the lower
    // NCH_S channels of the wide vector.
    assign bus40.d         = bus64.d[NCH_S*WIDTH-1:0];
    assign bus40.sel       = bus64.sel;
    assign bus40.in_valid  = bus64.in_valid;
    assign bus40.scan_en   = bus64.scan_en;
    assign bus40.out_ready = bus64.out_ready;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Channel value straight from the packing rule: out-of-range reads zero.
    function automatic logic [WIDTH-1:0] refChan(input logic [NCH*WIDTH-1:0] dv,
                                                 input int idx, input int nch);
        if (idx >= nch) return '0;
        return dv[idx*WIDTH +: WIDTH];
    endfunction

    function automatic logic [NCH*WIDTH-1:0] randD();
        logic [NCH*WIDTH-1:0] r;
        for (int i = 0; i < NCH*WIDTH/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Pattern where channel k carries k mod 16.
    function automatic logic [NCH*WIDTH-1:0] patD();
        logic [NCH*WIDTH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*WIDTH +: WIDTH] = WIDTH'(k % 16);
        return r;
    endfunction

    // One comparison: counts it, and reports a failure with both values.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then predicts what the
    // coming rising edge accepts. Acceptance follows the in_ready handshake;
    // the data and index expected for it come from the channel rules and the
    // mode model.
    task automatic applyStimulus(input logic [NCH*WIDTH-1:0] dv,
                                 input logic [SELW-1:0] s, input logic iv,
                                 input logic se, input logic ordy,
                                 input bit strict);
        logic exp_rdy64, exp_rdy40;
        @(negedge clk);
        bus64.d         = dv;
        bus64.sel       = s;
        bus64.in_valid  = iv;
        bus64.scan_en   = se;
        bus64.out_ready = ordy;
        #1;
        exp_rdy64 = ordy | ~bus64.out_valid;
        exp_rdy40 = ordy | ~bus40.out_valid;
        checkOutput("in_ready64", 32'(bus64.in_ready), 32'(exp_rdy64));
        checkOutput("in_ready40", 32'(bus40.in_ready), 32'(exp_rdy40));
        if (scan_mode) begin
            if (bus64.in_ready === 1'b1) begin
                q64.push_back('{SELW'(cnt64), refChan(dv, cnt64, NCH), cycle, strict});
                cnt64 = (cnt64 + 1) % NCH;
            end
            if (bus40.in_ready === 1'b1) begin
                q40.push_back('{SELW'(cnt40), refChan(dv, cnt40, NCH_S), cycle, strict});
                cnt40 = (cnt40 + 1) % NCH_S;
            end
        end else if (iv) begin
            if (bus64.in_ready === 1'b1)
                q64.push_back('{s, refChan(dv, int'(s), NCH), cycle, strict});
            if (bus40.in_ready === 1'b1)
                q40.push_back('{s, refChan(dv, int'(s), NCH_S), cycle, strict});
        end
        if (SCAN_BUILD) begin
            if (!scan_mode && se) begin
                scan_mode = 1'b1;
                cnt64     = 0;
                cnt40     = 0;
            end else if (scan_mode && !se) begin
                scan_mode = 1'b0;
            end
        end
    endtask

    // Holds reset across one rising edge, discards everything in flight and
    // checks the cleared outputs right after that edge.
    task automatic resetDut();
        @(negedge clk);
        reset           = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.scan_en   = 1'b0;
        bus64.out_ready = 1'b0;
        q64.delete();
        q40.delete();
        scan_mode  = 1'b0;
        cnt64      = 0;
        cnt40      = 0;
        prev_stall = '{1'b0, 1'b0};
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid64", 32'(bus64.out_valid), 32'd0);
        checkOutput("rst_y64",         32'(bus64.y),         32'd0);
        checkOutput("rst_y_ch64",      32'(bus64.y_ch),      32'd0);
        checkOutput("rst_out_valid40", 32'(bus40.out_valid), 32'd0);
        checkOutput("rst_y40",         32'(bus40.y),         32'd0);
        reset = 1'b0;
    endtask

    // Per-instance monitor body: stall hold, spurious output, data/index,
    // and exact two-cycle latency for requests issued under free flow.
    task automatic monitorOne(input int w);
        logic             ov, ordy;
        logic [WIDTH-1:0] yy;
        logic [SELW-1:0]  ch;
        exp_t             e;
        bit               have;
        if (w == 0) begin
            ov = bus64.out_valid; ordy = bus64.out_ready; yy = bus64.y; ch = bus64.y_ch;
            have = (q64.size() > 0);
        end else begin
            ov = bus40.out_valid; ordy = bus40.out_ready; yy = bus40.y; ch = bus40.y_ch;
            have = (q40.size() > 0);
        end
        if (prev_stall[w]) begin
            checkOutput($sformatf("hold_valid%0d", w), 32'(ov), 32'd1);
            checkOutput($sformatf("hold_y%0d", w),     32'(yy), 32'(prev_y[w]));
            checkOutput($sformatf("hold_y_ch%0d", w),  32'(ch), 32'(prev_ch[w]));
        end
        if (ov === 1'b1 && ordy === 1'b1) begin
            if (!have) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL spurious_out%0d: got out_valid=1 y_ch=%0d, expected no result (cycle %0d)",
                         w, ch, cycle);
            end else begin
                if (w == 0) e = q64.pop_front();
                else        e = q40.pop_front();
                checkOutput($sformatf("y%0d", w),    32'(yy), 32'(e.y));
                checkOutput($sformatf("y_ch%0d", w), 32'(ch), 32'(e.ch));
                if (e.strict)
                    checkOutput($sformatf("latency%0d", w), 32'(cycle - e.acc), 32'd2);
            end
        end
        prev_stall[w] = (ov === 1'b1) && (ordy !== 1'b1);
        prev_y[w]     = yy;
        prev_ch[w]    = ch;
    endtask

    // Monitor runs after the stimulus has settled each low phase.
    always @(negedge clk) begin
        #2;
        if (reset !== 1'b1) begin
            monitorOne(0);
            monitorOne(1);
        end else begin
            prev_stall = '{1'b0, 1'b0};
        end
    end

    // Directed scenarios first, then a randomized run, then a bounded drain.
    initial begin
        logic [NCH*WIDTH-1:0] dp;
        logic                 se;
        int                   drain;

        reset           = 1'b1;
        bus64.d         = '0;
        bus64.sel       = '0;
        bus64.in_valid  = 1'b0;
        bus64.scan_en   = 1'b0;
        bus64.out_ready = 1'b1;
        resetDut();

        // Single request sel=37 against the k mod 16 pattern.
        dp = patD();
        applyStimulus(dp, 6'd37, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(dp, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back 0, 63, 32, then 45 (out of range for the 40-channel copy).
        applyStimulus(dp, 6'd0,  1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(dp, 6'd63, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(dp, 6'd32, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(dp, 6'd45, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(dp, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Stall with results in flight, then release; d changes meanwhile.
        applyStimulus(dp, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(dp, 6'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(dp, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(randD(), 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) applyStimulus(randD(), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset with two results in flight; nothing stale may follow.
        applyStimulus(dp, 6'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(dp, 6'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        resetDut();
        repeat (4) applyStimulus(dp, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Scan run long enough to wrap; then manual selection resumes.
        repeat (72) applyStimulus(dp, SELW'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(dp, 6'd21, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(dp, 6'd50, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) applyStimulus(dp, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic: random data, indices, strobes, back-pressure
        // and occasional mode changes.
        se = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) se = ~se;
            applyStimulus(randD(), SELW'($urandom), 1'($urandom_range(0, 2) != 0),
                          se, 1'($urandom_range(0, 9) < 7), 1'b0);
            if (i == 700) resetDut();
        end

        // Drain everything still expected, within a fixed cycle budget.
        drain = 0;
        while ((q64.size() > 0 || q40.size() > 0 || scan_mode) && drain < 60) begin
            applyStimulus(randD(), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            drain++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain_left64", 32'(q64.size()), 32'd0);
        checkOutput("drain_left40", 32'(q40.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data bits per channel.
REQ-002 SHALL have parameter NCH, default 64: number of input channels, legal range 2..256.
REQ-003 SHALL have parameter SELW, default 6: select/index width, with 2**SELW >= NCH.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: d  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 Port: sel  input  SELW  channel index in manual mode.
REQ-008 Port: in_valid  input  1  manual-mode request strobe.
REQ-009 Port: in_ready  output  1  request accepted this cycle when high.
REQ-010 Port: scan_en  input  1  requests scan mode (level).
REQ-011 Port: y  output  WIDTH  selected channel data.
REQ-012 Port: y_ch  output  SELW  index of channel presented on y.
REQ-013 Port: out_valid  output  1  y/y_ch hold a valid result.
REQ-014 Port: out_ready  input  1  consumer accepts result when high with out_valid.

Function
REQ-015 Selection SHALL be a two-stage pipeline: stage 1 registers the selected entry of the lower-half and upper-half channel groups plus index and valid; stage 2 registers the final pick by the index MSB.
REQ-016 Latency SHALL be exactly 2 cycles from an accepted request to out_valid with no stall.
REQ-017 Pipeline enable SHALL be en = out_ready | ~out_valid; with en low, every pipeline register SHALL hold.
REQ-018 in_ready SHALL equal en; a request is accepted when its valid is high and en is high.
REQ-019 An index >= NCH SHALL produce y = 0 with y_ch carrying that index and out_valid asserted normally.
REQ-020 Data SHALL be sampled from d in the cycle the request is accepted; later d changes SHALL NOT affect that result.
REQ-021 The mode FSM SHALL have states MANUAL and SCAN.
REQ-022 MANUAL -> SCAN SHALL occur on the first edge with scan_en=1; the scan counter SHALL load 0 on that transition.
REQ-023 SCAN -> MANUAL SHALL occur on the first edge with scan_en=0; in-flight results SHALL still drain.
REQ-024 In MANUAL, the issued index SHALL be sel and the issued valid in_valid.
REQ-025 In SCAN, the issued index SHALL be the counter, the issued valid SHALL be 1, and sel/in_valid SHALL be ignored.
REQ-026 The counter SHALL increment only on an accepted SCAN issue and SHALL wrap from NCH-1 to 0.
REQ-027 With in_valid=0 in MANUAL, bubbles SHALL propagate: out_valid deasserts 2 cycles later when not stalled.

Reset
REQ-028 Reset SHALL force y=0, y_ch=0, out_valid=0, all stage-1 registers to 0, FSM state MANUAL, and counter 0, on the next edge.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results with no output transfer, regardless of out_ready.
REQ-030 Reset SHALL take priority over scan_en, in_valid and the stall hold.

Configuration
REQ-031 Macro SCAN_MUX_SCAN_EN defined: the FSM and scan counter SHALL exist as specified.
REQ-032 Macro SCAN_MUX_SCAN_EN undefined: the FSM and counter SHALL be absent, scan_en SHALL be ignored, and the block SHALL behave permanently as MANUAL.

Verification
REQ-033 Defaults, d channel k = k mod 16, out_ready=1, in_valid pulses with sel=37 -> two cycles later y=5, y_ch=37, out_valid=1 for one cycle.
REQ-034 Back-to-back sel=0,63,32 with in_valid=1, out_ready=1 -> y = 0,15,0 with y_ch 0,63,32 on consecutive cycles starting at cycle 2.
REQ-035 out_ready=0 while out_valid=1, hold 3 cycles -> y/y_ch stable and in_ready=0; release -> no result lost or duplicated.
REQ-036 NCH=40, sel=45 accepted -> y=0, y_ch=45, out_valid=1.
REQ-037 scan_en=1 for 70 accepted issues, out_ready=1 -> y_ch sequence 0..63,0..5; scan_en=0 -> sel mode resumes next cycle.
REQ-038 reset asserted with 2 results in flight -> out_valid=0, y=0 next edge; no stale output after deassertion.
